slink_prbs_tester: RTL

- Parametrised multi-channel, multi-lane PRBS generator and self-synchronising checker for serial-link lanes.
- Used in chip-level fixtures and pad loopback tests, replacing hard-wired single-channel lane connections.
- Per channel: drives a PRBS pattern on the TX lanes, checks the RX lanes, reports lock, sticky loss and a saturating bit-error count.
- Supports PRBS7 and PRBS15, and error injection on demand.

---
 rtl/slink_prbs_tester.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/slink_prbs_tester.sv
// Multi-channel, multi-lane PRBS7/PRBS15 generator with a self-synchronising checker per channel.
// Each channel reports lock, sticky loss of lock, and a saturating bit-error count.
module slink_prbs_tester #(
    parameter int NumChan     = 1,
    parameter int NumLanes    = 4,
    parameter int LockCount   = 16,
    parameter int LossCount   = 8,
    parameter int ErrCntWidth = 16
) (
    input  logic                            clk_i,
    input  logic                            rst_ni,
    input  logic                            en_i,
    input  logic                            mode_i,
    input  logic                            clr_i,
    input  logic [NumChan-1:0]              inject_err_i,
    output logic [NumChan*NumLanes-1:0]     tx_o,
    input  logic [NumChan*NumLanes-1:0]     rx_i,
    output logic [NumChan-1:0]              locked_o,
    output logic [NumChan-1:0]              lost_o,
    output logic [NumChan*ErrCntWidth-1:0]  err_cnt_o
);

    // state  | meaning
    // ACQ    | acquiring: counting down consecutive clean cycles towards lock
    // LOCKED | locked: counting bit errors, counting down consecutive bad cycles towards loss
    typedef enum logic {ACQ = 1'b0, LOCKED = 1'b1} state_e;

    localparam int PopW  = $clog2(NumLanes + 1);
    localparam int SumW  = ((ErrCntWidth > PopW) ? ErrCntWidth : PopW) + 1;
    localparam int LockW = $clog2(LockCount + 1);
    localparam int LossW = $clog2(LossCount + 1);
    localparam logic [LockW-1:0] LockLoad = LockW'(LockCount - 1);
    localparam logic [LossW-1:0] LossLoad = LossW'(LossCount - 1);
    localparam logic [SumW-1:0]  ErrMax   = SumW'({ErrCntWidth{1'b1}});

    function automatic logic tap_fb(input logic [14:0] v, input logic m15);
        return m15 ? (v[14] ^ v[13]) : (v[6] ^ v[5]);
    endfunction

    function automatic logic win_zero(input logic [14:0] v, input logic m15);
        return m15 ? (v == 15'd0) : (v[6:0] == 7'd0);
    endfunction

    logic mode_q;
    logic restart;

    // A mode change behaves like a one-cycle disable so both ends reseed together.
    assign restart = !en_i || (mode_i != mode_q);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mode_q <= 1'b0;
        end else begin
            mode_q <= mode_i;
        end
    end

    for (genvar c = 0; c < NumChan; c++) begin : g_chan
        logic [14:0]            lfsr_q [NumLanes];
        logic [14:0]            chk_q  [NumLanes];
        logic [NumLanes-1:0]    tx_q;
        logic [NumLanes-1:0]    mism;
        logic [NumLanes-1:0]    zero;
        logic [PopW-1:0]        pop;
        logic [SumW-1:0]        sum;
        logic [ErrCntWidth-1:0] err_inc;
        logic                   clean;

        state_e                 state_q;
        logic [LockW-1:0]       lock_rem_q;
        logic [LossW-1:0]       loss_rem_q;
        logic                   locked_q;
        logic                   lost_q;
        logic [ErrCntWidth-1:0] err_q;

        always_comb begin
            mism = '0;
            zero = '0;
            pop  = '0;
            for (int l = 0; l < NumLanes; l++) begin
                mism[l] = rx_i[c*NumLanes + l] ^ tap_fb(chk_q[l], mode_i);
                zero[l] = win_zero(chk_q[l], mode_i);
                pop     = pop + PopW'(mism[l]);
            end
            clean   = !(|mism) && !(|zero);
            sum     = SumW'(err_q) + SumW'(pop);
            err_inc = (sum > ErrMax) ? '1 : sum[ErrCntWidth-1:0];
        end

        // Injection flips only the registered TX bit; the LFSR keeps its true sequence.
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                for (int l = 0; l < NumLanes; l++) begin
                    lfsr_q[l] <= 15'(l + 1);
                    chk_q[l]  <= '0;
                end
                tx_q <= '0;
            end else if (restart) begin
                for (int l = 0; l < NumLanes; l++) begin
                    lfsr_q[l] <= 15'(l + 1);
                end
                tx_q <= '0;
            end else begin
                for (int l = 0; l < NumLanes; l++) begin
                    lfsr_q[l] <= mode_i ? {lfsr_q[l][13:0], tap_fb(lfsr_q[l], 1'b1)}
                                        : {8'd0, lfsr_q[l][5:0], tap_fb(lfsr_q[l], 1'b0)};
                    tx_q[l]   <= tap_fb(lfsr_q[l], mode_i) ^ ((l == 0) && inject_err_i[c]);
                    chk_q[l]  <= {chk_q[l][13:0], rx_i[c*NumLanes + l]};
                end
            end
        end

        // clr_i is applied first so that a loss in the same cycle still sets lost.
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                state_q    <= ACQ;
                lock_rem_q <= LockLoad;
                loss_rem_q <= LossLoad;
                locked_q   <= 1'b0;
                lost_q     <= 1'b0;
                err_q      <= '0;
            end else begin
                if (clr_i) begin
                    err_q  <= '0;
                    lost_q <= 1'b0;
                end
                if (restart) begin
                    state_q    <= ACQ;
                    lock_rem_q <= LockLoad;
                    loss_rem_q <= LossLoad;
                    locked_q   <= 1'b0;
                end else begin
                    case (state_q)
                        ACQ: begin
                            if (!clean) begin
                                lock_rem_q <= LockLoad;
                            end else if (lock_rem_q == '0) begin
                                state_q    <= LOCKED;
                                locked_q   <= 1'b1;
                                loss_rem_q <= LossLoad;
                            end else begin
                                lock_rem_q <= lock_rem_q - LockW'(1);
                            end
                        end
                        LOCKED: begin
                            if (!clr_i) begin
                                err_q <= err_inc;
                            end
                            if (clean) begin
                                loss_rem_q <= LossLoad;
                            end else if (loss_rem_q == '0) begin
                                state_q    <= ACQ;
                                locked_q   <= 1'b0;
                                lost_q     <= 1'b1;
                                lock_rem_q <= LockLoad;
                            end else begin
                                loss_rem_q <= loss_rem_q - LossW'(1);
                            end
                        end
                    endcase
                end
            end
        end

        assign tx_o[c*NumLanes +: NumLanes]          = tx_q;
        assign locked_o[c]                           = locked_q;
        assign lost_o[c]                             = lost_q;
        assign err_cnt_o[c*ErrCntWidth +: ErrCntWidth] = err_q;
    end

endmodule
